// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM states shared by the sequential ALU
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_SRA = 4'd8,
    OP_MUL = 4'd9
  } op_e;
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: one-bit-per-cycle shifter and shift-add multiplier (multiplier only with ALU_MUL_EN)
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
`ifdef ALU_MUL_EN
  input  logic [WIDTH-1:0]   b,
`endif
  input  logic [SHAMT_W:0]   count,
  output logic               done,
  output logic [WIDTH-1:0]   res,
  output logic               carry
);
  localparam logic [SHAMT_W:0] ONE = (SHAMT_W+1)'(1);
  logic active, sh_c;
  logic [3:0] op_r, op_c;
  logic [SHAMT_W:0] cnt, rem;
  logic [WIDTH-1:0] acc, src, sh_res;
  // the start cycle already performs the first step, so n steps finish n-1 cycles later
  assign op_c   = start ? op : op_r;
  assign src    = start ? a : acc;
  assign rem    = start ? count : cnt;
  assign done   = (start || active) && rem == ONE;
  assign sh_res = op_c == OP_SHL ? {src[WIDTH-2:0], 1'b0}
                                 : {op_c == OP_SRA && src[WIDTH-1], src[WIDTH-1:1]};
  assign sh_c   = op_c == OP_SHL ? src[WIDTH-1] : src[0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      op_r   <= '0;
      cnt    <= '0;
      acc    <= '0;
    end else if (start || active) begin
      active <= !done;
      op_r   <= op_c;
      cnt    <= rem - ONE;
      acc    <= sh_res;
    end
  end
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] p, m, q, sp, sm, sq, p_n;
  assign sp    = start ? '0 : p;
  assign sm    = start ? a : m;
  assign sq    = start ? b : q;
  assign p_n   = sp + (sq[0] ? sm : '0);
  assign res   = op_c == OP_MUL ? p_n : sh_res;
  assign carry = op_c != OP_MUL && sh_c;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
      m <= '0;
      q <= '0;
    end else if (start || active) begin
      p <= p_n;
      m <= sm << 1;
      q <= sq >> 1;
    end
  end
`else
  assign res   = sh_res;
  assign carry = sh_c;
`endif
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes and ZNCV flags; ALU_MUL_EN enables op 9 multiply
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [3:0]       out_flags,
  output logic             out_err,
  output logic             busy
);
  state_e state;
  logic accept, is_shift, is_mul, illegal, start, load, sub;
  logic u_done, u_carry, c_c, c_v, c_nxt, v_nxt, e_nxt;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0] b_eff, c_res, r_nxt, u_res;
  logic [WIDTH:0] sum;
  logic [3:0] f_nxt;
  assign in_ready  = state == IDLE;
  assign busy      = state == BUSY;
  assign out_valid = state == DONE;
  assign accept    = in_valid && in_ready;
  assign shamt     = in_b[SHAMT_W-1:0];
  assign is_shift  = in_op == OP_SHL || in_op == OP_SHR || in_op == OP_SRA;
`ifdef ALU_MUL_EN
  assign illegal = in_op > OP_MUL;
  assign is_mul  = in_op == OP_MUL;
`else
  assign illegal = in_op >= OP_MUL;
  assign is_mul  = 1'b0;
`endif
  // a zero shift completes like a single-cycle op and never starts the iteration unit
  assign start = accept && (is_mul || (is_shift && shamt != '0));
  assign load  = (accept && (!start || u_done)) || (state == BUSY && u_done);
  assign sub   = in_op == OP_SUB;
  assign b_eff = sub ? ~in_b : in_b;
  assign sum   = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  alu_iter_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (in_op),
    .a     (in_a),
`ifdef ALU_MUL_EN
    .b     (in_b),
`endif
    .count (is_mul ? (SHAMT_W+1)'(WIDTH) : {1'b0, shamt}),
    .done  (u_done),
    .res   (u_res),
    .carry (u_carry)
  );
  always_comb begin
    c_res = '0;
    c_c   = 1'b0;
    c_v   = 1'b0;
    case (in_op)
      OP_ADD, OP_SUB: begin
        c_res = sum[WIDTH-1:0];
        c_c   = sum[WIDTH];
        c_v   = in_a[WIDTH-1] == b_eff[WIDTH-1] && sum[WIDTH-1] != in_a[WIDTH-1];
      end
      OP_AND: c_res = in_a & in_b;
      OP_OR:  c_res = in_a | in_b;
      OP_XOR: c_res = in_a ^ in_b;
      OP_NOT: c_res = ~in_a;
      OP_SHL, OP_SHR, OP_SRA: begin
        c_res = shamt == '0 ? in_a : u_res;
        c_c   = shamt != '0 && u_carry;
      end
      default: ;
    endcase
  end
  always_comb begin
    r_nxt        = state == BUSY ? u_res : c_res;
    c_nxt        = state == BUSY ? u_carry : c_c;
    v_nxt        = state == BUSY ? 1'b0 : c_v;
    e_nxt        = state == BUSY ? 1'b0 : illegal;
    f_nxt        = '0;
    f_nxt[FLG_Z] = !e_nxt && r_nxt == '0;
    f_nxt[FLG_N] = r_nxt[WIDTH-1];
    f_nxt[FLG_C] = c_nxt;
    f_nxt[FLG_V] = v_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_res   <= '0;
      out_flags <= '0;
      out_err   <= 1'b0;
    end else begin
      state <= state == IDLE ? (accept ? (load ? DONE : BUSY) : IDLE)
             : state == BUSY ? (u_done ? DONE : BUSY)
             : (out_ready ? IDLE : DONE);
      if (load) begin
        out_res   <= r_nxt;
        out_flags <= f_nxt;
        out_err   <= e_nxt;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results, flags and latencies for alu_seq
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] in_op = '0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [15:0] out_res;
  logic [3:0] out_flags;
  logic out_err;
  logic busy;
  int n_run = 0;
  int n_fail = 0;
  alu_seq #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags),
    .out_err   (out_err),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     output int lat, output logic b1);
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    b1 = busy;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drained"}, {out_valid, in_ready}, 2'b01);
  endtask
  task automatic vec(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] res, input logic [3:0] flg, input logic err, input int elat,
                     input logic ebusy);
    int lat;
    logic b1;
    run(op, a, b, lat, b1);
    chk({tag, "_res"}, out_res, res);
    chk({tag, "_flags"}, out_flags, flg);
    chk({tag, "_err"}, out_err, err);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_busy"}, b1, ebusy);
    drain(tag);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outs", {out_valid, out_res, out_flags, out_err, busy}, '0);
    chk("rst_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {in_ready, out_valid}, 2'b10);
    vec("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1'b0, 1, 1'b0);
    vec("sub_zero", 4'd1, 16'h0005, 16'h0005, 16'h0000, 4'b1010, 1'b0, 1, 1'b0);
    vec("sub_borrow", 4'd1, 16'h0000, 16'h0001, 16'hFFFF, 4'b0100, 1'b0, 1, 1'b0);
    vec("and", 4'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b0, 1, 1'b0);
    vec("or", 4'd3, 16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000, 1'b0, 1, 1'b0);
    vec("xor", 4'd4, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000, 1'b0, 1, 1'b0);
    vec("not", 4'd5, 16'h00FF, 16'h1234, 16'hFF00, 4'b0100, 1'b0, 1, 1'b0);
    vec("shl3", 4'd6, 16'h8001, 16'h0003, 16'h0008, 4'b0000, 1'b0, 3, 1'b1);
    vec("sra15", 4'd8, 16'h8000, 16'h000F, 16'hFFFF, 4'b0100, 1'b0, 15, 1'b1);
    vec("shr0", 4'd7, 16'h1234, 16'h0000, 16'h1234, 4'b0000, 1'b0, 1, 1'b0);
    vec("shr1", 4'd7, 16'h0003, 16'h0001, 16'h0001, 4'b0010, 1'b0, 1, 1'b0);
    vec("shl1_c", 4'd6, 16'h8000, 16'h0011, 16'h0000, 4'b1010, 1'b0, 1, 1'b0);
`ifdef ALU_MUL_EN
    vec("mul", 4'd9, 16'h0012, 16'h0034, 16'h03A8, 4'b0000, 1'b0, 16, 1'b1);
`else
    vec("mul_off", 4'd9, 16'h0012, 16'h0034, 16'h0000, 4'b0000, 1'b1, 1, 1'b0);
`endif
    vec("illegal_f", 4'hF, 16'h1111, 16'h2222, 16'h0000, 4'b0000, 1'b1, 1, 1'b0);
    vec("err_clear", 4'd0, 16'h0001, 16'h0001, 16'h0002, 4'b0000, 1'b0, 1, 1'b0);
    begin
      int lat;
      logic b1;
      run(4'd0, 16'h0001, 16'h0002, lat, b1);
      chk("bp_first", {out_valid, out_res}, {1'b1, 16'h0003});
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1; in_op = 4'd0; in_a = 16'h0005; in_b = 16'h0005;
        @(negedge clk);
        chk("bp_hold", {out_valid, in_ready, out_res, out_flags, out_err}, {2'b10, 16'h0003, 4'b0000, 1'b0});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_release", {out_valid, in_ready}, 2'b01);
      @(negedge clk);
      chk("bp_single", {out_valid, in_ready, out_res}, {2'b01, 16'h0003});
    end
    @(negedge clk);
    in_op = 4'd6; in_a = 16'h0001; in_b = 16'h000A; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_shl_busy", {busy, out_valid}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {out_valid, out_res, out_flags, out_err, busy}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("post_rst", {in_ready, out_valid, busy}, 3'b100);
    end
    vec("post_rst_add", 4'd0, 16'h1000, 16'h0234, 16'h1234, 4'b0000, 1'b0, 1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
